axi_vdma_wr_burst_sched: RTL

Sequences the AXI write state core for the VDMA write path. Splits each video frame into bursts of at most BURST_LEN beats and issues one write request per burst, gated by line-buffer FIFO occupancy. Tracks the burst address and rotates through FRAME_NUM frame buffers. Sits between the video-in FIFO (fill level) and the write state core (write_req/req_len/req_addr/req_done).

---
 rtl/vdma_pkg.sv | 21 ++
 rtl/vdma_frame_ptr.sv | 23 ++
 rtl/axi_vdma_wr_burst_sched.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/vdma_pkg.sv
// Shared VDMA definitions: scheduler state encoding and AXI constants
// common to the write burst scheduler and the write state core.
package vdma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DATA = 3'd1,
    ST_REQ       = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_FRAME_END = 3'd4
  } sched_state_t;

  // 32-byte beats, matching awsize 3'b101 on the write core
  localparam int unsigned VDMA_BYTES_PER_BEAT = 32;
  localparam logic [2:0]  VDMA_AXI_SIZE       = 3'b101;
  localparam logic [1:0]  VDMA_AXI_BURST_INCR = 2'b01;

  // AXI bursts must never straddle a 4 KB boundary
  localparam int unsigned VDMA_4K_BYTES = 4096;

endpackage

// File: rtl/vdma_frame_ptr.sv
// Frame-buffer index rotator: steps 0..FRAME_NUM-1 and wraps.
// Kept separate so the read-side scheduler can reuse it.
module vdma_frame_ptr #(
  parameter int unsigned FRAME_NUM = 3
) (
  input  logic       axi_aclk,
  input  logic       axi_resetn,
  input  logic       advance,
  output logic [1:0] index
);

  localparam logic [1:0] LAST_INDEX = 2'(FRAME_NUM - 1);

  // Advance the buffer pointer once per completed frame
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      index <= 2'd0;
    end else if (advance) begin
      index <= (index == LAST_INDEX) ? 2'd0 : index + 2'd1;
    end
  end

endmodule

// File: rtl/axi_vdma_wr_burst_sched.sv
// VDMA write-path burst scheduler: splits each frame into bursts of at
// most BURST_LEN beats, gates each burst on FIFO fill level, issues one
// request at a time to the write core and rotates through frame buffers.
module axi_vdma_wr_burst_sched
  import vdma_pkg::*;
#(
  parameter int unsigned     ASIZE          = 32,
  parameter int unsigned     LSIZE          = 8,
  parameter int unsigned     CSIZE          = 10,
  parameter int unsigned     FSIZE          = 24,
  parameter int unsigned     BURST_LEN      = 64,
  parameter int unsigned     BYTES_PER_BEAT = VDMA_BYTES_PER_BEAT,
  parameter logic [ASIZE-1:0] BASE_ADDR     = 32'h0000_0000,
  parameter logic [ASIZE-1:0] FRAME_STRIDE  = 32'h0080_0000,
  parameter int unsigned     FRAME_NUM      = 3
) (
  input  logic             axi_aclk,
  input  logic             axi_resetn,
  input  logic             enable,
  input  logic             vs_start,
  input  logic [FSIZE-1:0] cfg_frame_beats,
  input  logic [CSIZE-1:0] fifo_count,
  output logic             write_req,
  output logic [LSIZE-1:0] req_len,
  output logic [ASIZE-1:0] req_addr,
  input  logic             req_done,
  input  logic             req_err,
  output logic [1:0]       frame_index,
  output logic             frame_done,
  output logic             frame_skip,
  output logic             err_flag,
  output logic             busy
);

  // Bad parameter sets are rejected at elaboration rather than producing
  // bursts that cross a 4 KB page
  if ((BURST_LEN < 1) || (BURST_LEN > (1 << LSIZE))) begin : g_bad_burst_len
    $error("axi_vdma_wr_burst_sched: BURST_LEN out of range");
  end
  if ((VDMA_4K_BYTES % (BURST_LEN * BYTES_PER_BEAT)) != 0) begin : g_bad_burst_bytes
    $error("axi_vdma_wr_burst_sched: BURST_LEN*BYTES_PER_BEAT must divide 4096");
  end
  if ((BASE_ADDR[11:0] != 12'd0) || (FRAME_STRIDE[11:0] != 12'd0)) begin : g_bad_align
    $error("axi_vdma_wr_burst_sched: BASE_ADDR and FRAME_STRIDE must be 4 KB aligned");
  end
  if ((FRAME_NUM < 1) || (FRAME_NUM > 4)) begin : g_bad_frame_num
    $error("axi_vdma_wr_burst_sched: FRAME_NUM must be 1..4");
  end

  localparam int unsigned     CMPW        = (CSIZE > FSIZE) ? CSIZE : FSIZE;
  localparam logic [FSIZE-1:0] BURST_CHUNK = FSIZE'(BURST_LEN);

  sched_state_t     state;
  sched_state_t     next_state;
  logic [FSIZE-1:0] remaining;
  logic [ASIZE-1:0] addr;
  logic [FSIZE-1:0] chunk;
  logic [FSIZE-1:0] remaining_after;
  logic [ASIZE-1:0] frame_base;
  logic             fifo_ok;
  logic             start_frame;

  assign chunk           = (remaining < BURST_CHUNK) ? remaining : BURST_CHUNK;
  assign remaining_after = remaining - chunk;
  assign frame_base      = BASE_ADDR + ASIZE'(frame_index) * FRAME_STRIDE;
  assign fifo_ok         = CMPW'(fifo_count) >= CMPW'(chunk);
  assign start_frame     = (state == ST_IDLE) && vs_start && enable;

  vdma_frame_ptr #(
    .FRAME_NUM (FRAME_NUM)
  ) u_frame_ptr (
    .axi_aclk   (axi_aclk),
    .axi_resetn (axi_resetn),
    .advance    (state == ST_FRAME_END),
    .index      (frame_index)
  );

  // Scheduler state register
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; an aborted frame only leaves at a burst boundary
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (vs_start && enable) begin
          next_state = (cfg_frame_beats == '0) ? ST_FRAME_END : ST_WAIT_DATA;
        end
      end
      ST_WAIT_DATA: begin
        if (!enable) begin
          next_state = ST_IDLE;
        end else if (fifo_ok) begin
          next_state = ST_REQ;
        end
      end
      ST_REQ: begin
        next_state = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (req_done) begin
          if (remaining_after == '0) begin
            next_state = ST_FRAME_END;
          end else if (!enable) begin
            next_state = ST_IDLE;
          end else begin
            next_state = ST_WAIT_DATA;
          end
        end
      end
      ST_FRAME_END: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Registered status pulses, timed so they are high alongside their state
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      write_req  <= 1'b0;
      frame_done <= 1'b0;
      frame_skip <= 1'b0;
      busy       <= 1'b0;
    end else begin
      write_req  <= (next_state == ST_REQ);
      frame_done <= (next_state == ST_FRAME_END);
      frame_skip <= vs_start && (state != ST_IDLE);
      busy       <= (next_state != ST_IDLE);
    end
  end

  // Frame and burst bookkeeping: remaining beats, burst address, request fields, error flag
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      remaining <= '0;
      addr      <= '0;
      req_len   <= '0;
      req_addr  <= '0;
      err_flag  <= 1'b0;
    end else begin
      if (start_frame) begin
        remaining <= cfg_frame_beats;
        addr      <= frame_base;
        err_flag  <= 1'b0;
      end
      if ((state == ST_WAIT_DATA) && enable && fifo_ok) begin
        req_len  <= LSIZE'(chunk - FSIZE'(1));
        req_addr <= addr;
      end
      if ((state == ST_WAIT_DONE) && req_done) begin
        addr      <= addr + ASIZE'(chunk) * ASIZE'(BYTES_PER_BEAT);
        remaining <= remaining_after;
        if (req_err) begin
          err_flag <= 1'b1;
        end
      end
    end
  end

endmodule
